// File: rtl/sg_lock_ctrl_pkg.sv
// Shared definitions for the sync-generator lock controller: FSM state
// encodings, default lock qualification settings and a distance helper.
package sg_lock_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_VERIFY  = 3'd3;
  localparam logic [2:0] ST_LOCKED  = 3'd4;

  localparam int DEF_STABLE_FRAMES = 4;
  localparam int DEF_MISS_LIMIT    = 2;
  localparam int DEF_H_TOL         = 4;
  localparam int DEF_V_TOL         = 1;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sg_lock_ctrl_meas.sv
// Measures the synchronised sync reference: line period, lines per frame and
// a frame timeout, all in PCLK cycles.
module sg_lock_ctrl_meas
  import sg_lock_ctrl_pkg::*;
#(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11,
  parameter int TMO_W  = 22
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              frame_done_o,
  output logic [HCNT_W-1:0] hp_cur_o,
  output logic [VCNT_W-1:0] ln_cur_o,
  output logic              timeout_o
);

  logic              hs_prev_q, vs_prev_q;
  logic [HCNT_W-1:0] hcnt_q, hp_cur_q, hcnt_inc;
  logic [VCNT_W-1:0] lcnt_q, ln_cur_q, lcnt_inc;
  logic [TMO_W-1:0]  tmo_q;
  logic              hs_fall, vs_fall;

  assign hs_fall  = hs_prev_q & ~hsync_i;
  assign vs_fall  = vs_prev_q & ~vsync_i;
  assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + 1'b1;
  assign lcnt_inc = (&lcnt_q) ? lcnt_q : lcnt_q + 1'b1;

  // A line edge coinciding with the frame edge belongs to the frame that is ending.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      hcnt_q    <= '0;
      hp_cur_q  <= '0;
      lcnt_q    <= '0;
      ln_cur_q  <= '0;
      tmo_q     <= '0;
    end else begin
      hs_prev_q <= hsync_i;
      vs_prev_q <= vsync_i;
      if (clr_i) begin
        hcnt_q <= '0;
        lcnt_q <= '0;
        tmo_q  <= '0;
      end else begin
        hcnt_q <= hs_fall ? '0 : hcnt_inc;
        if (hs_fall) hp_cur_q <= hcnt_inc;
        if (vs_fall) begin
          ln_cur_q <= hs_fall ? lcnt_inc : lcnt_q;
          lcnt_q   <= '0;
        end else if (hs_fall) begin
          lcnt_q <= lcnt_inc;
        end
        tmo_q <= vs_fall ? '0 : tmo_q + 1'b1;
      end
    end
  end

  assign frame_done_o = vs_fall & ~clr_i;
  assign timeout_o    = (&tmo_q) & ~clr_i;
  assign hp_cur_o     = hp_cur_q;
  assign ln_cur_o     = ln_cur_q;

endmodule

// File: rtl/sg_lock_ctrl.sv
// Lock sequencer for the output sync generator: qualifies a stable reference
// mode over several frames before releasing syncgen, then supervises lock.
module sg_lock_ctrl
  import sg_lock_ctrl_pkg::*;
#(
  parameter int HCNT_W        = 12,
  parameter int VCNT_W        = 11,
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES,
  parameter int MISS_LIMIT    = DEF_MISS_LIMIT,
  parameter int H_TOL         = DEF_H_TOL,
  parameter int V_TOL         = DEF_V_TOL,
  parameter int TMO_W         = 22
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              v_change_i,
  input  logic              hsync_ref_i,
  input  logic              vsync_ref_i,
  input  logic              lost_clr_i,
  output logic              sg_reset_n_o,
  output logic              locked_o,
  output logic              lock_lost_o,
  output logic [HCNT_W-1:0] hperiod_o,
  output logic [VCNT_W-1:0] lines_o
);

  localparam int STAB_W = $clog2(STABLE_FRAMES + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  state_t            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [HCNT_W-1:0] hp_ref_q, hp_ref_d, hperiod_q, hperiod_d, hp_cur;
  logic [VCNT_W-1:0] ln_ref_q, ln_ref_d, lines_q, lines_d, ln_cur;
  logic              lost_q, lost_d, sg_rst_n_q, locked_q, eval_q;
  logic              frame_done, timeout, match;

  sg_lock_ctrl_meas #(
    .HCNT_W(HCNT_W),
    .VCNT_W(VCNT_W),
    .TMO_W (TMO_W)
  ) u_meas (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (state_q == ST_IDLE),
    .hsync_i     (hsync_ref_i),
    .vsync_i     (vsync_ref_i),
    .frame_done_o(frame_done),
    .hp_cur_o    (hp_cur),
    .ln_cur_o    (ln_cur),
    .timeout_o   (timeout)
  );

  // A saturated period or a degenerate line count never qualifies as a mode.
  assign match = (abs_diff(32'(ln_cur), 32'(ln_ref_q)) <= 32'(V_TOL)) &&
                 (abs_diff(32'(hp_cur), 32'(hp_ref_q)) <= 32'(H_TOL)) &&
                 (ln_cur >= VCNT_W'(2)) && !(&hp_cur);

  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    miss_d    = miss_q;
    hp_ref_d  = hp_ref_q;
    ln_ref_d  = ln_ref_q;
    hperiod_d = hperiod_q;
    lines_d   = lines_q;
    lost_d    = lost_q & ~lost_clr_i;
    if (!enable_i || v_change_i) begin
      state_d = ST_IDLE;
      stab_d  = '0;
      miss_d  = '0;
    end else if (timeout && state_q != ST_IDLE) begin
      if (state_q == ST_LOCKED) lost_d = 1'b1;
      state_d = ST_SYNC;
      stab_d  = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: if (eval_q) state_d = ST_MEASURE;
        ST_MEASURE: if (eval_q) begin
          hp_ref_d = hp_cur;
          ln_ref_d = ln_cur;
          stab_d   = STAB_W'(1);
          state_d  = ST_VERIFY;
        end
        ST_VERIFY: if (eval_q) begin
          if (match) begin
            stab_d = stab_q + 1'b1;
            if (stab_q == STAB_W'(STABLE_FRAMES - 1)) begin
              state_d   = ST_LOCKED;
              hperiod_d = hp_ref_q;
              lines_d   = ln_ref_q;
              miss_d    = '0;
            end
          end else begin
            hp_ref_d = hp_cur;
            ln_ref_d = ln_cur;
            stab_d   = STAB_W'(1);
          end
        end
        ST_LOCKED: if (eval_q) begin
          if (match) begin
            miss_d = '0;
          end else if (miss_q == MISS_W'(MISS_LIMIT - 1)) begin
            state_d = ST_SYNC;
            lost_d  = 1'b1;
            miss_d  = '0;
            stab_d  = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      stab_q     <= '0;
      miss_q     <= '0;
      hp_ref_q   <= '0;
      ln_ref_q   <= '0;
      hperiod_q  <= '0;
      lines_q    <= '0;
      lost_q     <= 1'b0;
      sg_rst_n_q <= 1'b0;
      locked_q   <= 1'b0;
      eval_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      miss_q     <= miss_d;
      hp_ref_q   <= hp_ref_d;
      ln_ref_q   <= ln_ref_d;
      hperiod_q  <= hperiod_d;
      lines_q    <= lines_d;
      lost_q     <= lost_d;
      sg_rst_n_q <= (state_d == ST_LOCKED);
      locked_q   <= (state_d == ST_LOCKED);
      eval_q     <= frame_done;
    end
  end

  assign sg_reset_n_o = sg_rst_n_q;
  assign locked_o     = locked_q;
  assign lock_lost_o  = lost_q;
  assign hperiod_o    = hperiod_q;
  assign lines_o      = lines_q;

endmodule

// File: tb/tb_sg_lock_ctrl.sv
// Directed frame-level bench for sg_lock_ctrl using scaled-down frames and a
// short frame timeout; each frame's expected outcome is queued when it is sent.
module tb_sg_lock_ctrl;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;
  localparam int TMO_W  = 12;

  logic              clk = 1'b0;
  logic              reset, enable, v_change, hsync, vsync, lost_clr;
  logic              sg_reset_n, locked, lock_lost;
  logic [HCNT_W-1:0] hperiod;
  logic [VCNT_W-1:0] lines;

  typedef struct {
    string tag;
    logic  rstN;
    logic  lck;
    logic  lost;
    int    hp;
    int    ln;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  sg_lock_ctrl #(
    .HCNT_W(HCNT_W),
    .VCNT_W(VCNT_W),
    .TMO_W (TMO_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .v_change_i  (v_change),
    .hsync_ref_i (hsync),
    .vsync_ref_i (vsync),
    .lost_clr_i  (lost_clr),
    .sg_reset_n_o(sg_reset_n),
    .locked_o    (locked),
    .lock_lost_o (lock_lost),
    .hperiod_o   (hperiod),
    .lines_o     (lines)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveCycle(input logic hs, input logic vs);
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input string tag, input logic rstN, input logic lck,
                         input logic lost, input int hp, input int ln);
    exp_t e;
    e.tag  = tag;
    e.rstN = rstN;
    e.lck  = lck;
    e.lost = lost;
    e.hp   = hp;
    e.ln   = ln;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) passes++;
    else begin
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".sg_reset_n"}, 32'(sg_reset_n), 32'(e.rstN));
    cmp({e.tag, ".locked"},     32'(locked),     32'(e.lck));
    cmp({e.tag, ".lock_lost"},  32'(lock_lost),  32'(e.lost));
    cmp({e.tag, ".hperiod"},    32'(hperiod),    32'(e.hp));
    cmp({e.tag, ".lines"},      32'(lines),      32'(e.ln));
  endtask

  // One frame: vsync and hsync fall together at its start, which also ends
  // the previous frame, so the previous frame's outcome is checked early on.
  task automatic applyStimulus(input int nLines, input int period, input int clrLine,
                               input int vchgLine, input string tag, input logic rstN,
                               input logic lck, input logic lost, input int hp, input int ln);
    for (int l = 0; l < nLines; l++) begin
      for (int c = 0; c < period; c++) begin
        lost_clr = (l == clrLine) && (c == 10);
        v_change = (l == vchgLine) && (c == 10);
        driveCycle(c >= 4, l >= 2);
        lost_clr = 1'b0;
        v_change = 1'b0;
        if (l == 0 && c == 3) checkOutput();
        if (l == vchgLine && c == 10) begin
          pushExp({tag, "_now"}, rstN, lck, lost, hp, ln);
          checkOutput();
        end
      end
    end
    pushExp(tag, rstN, lck, lost, hp, ln);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    v_change = 1'b0;
    lost_clr = 1'b0;
    hsync    = 1'b1;
    vsync    = 1'b1;
    repeat (3) driveCycle(1'b1, 1'b1);
    reset = 1'b0;
    driveCycle(1'b1, 1'b1);
    pushExp("reset", 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput();

    enable = 1'b1;
    repeat (10) driveCycle(1'b1, 1'b1);
    pushExp("sync_gap", 1'b0, 1'b0, 1'b0, 0, 0);

    applyStimulus(20, 32, -1, -1, "t1_measure", 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(20, 32, -1, -1, "t1_stab2",   1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(20, 32, -1, -1, "t1_stab3",   1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(20, 32, -1, -1, "t1_lock",    1'b1, 1'b1, 1'b0, 32, 20);

    applyStimulus(27, 32, -1, -1, "t2_miss1",   1'b1, 1'b1, 1'b0, 32, 20);
    applyStimulus(20, 32, -1, -1, "t2_recover", 1'b1, 1'b1, 1'b0, 32, 20);

    applyStimulus(27, 32, -1, -1, "t3_miss1",   1'b1, 1'b1, 1'b0, 32, 20);
    applyStimulus(27, 32, -1, -1, "t3_drop",    1'b0, 1'b0, 1'b1, 32, 20);
    applyStimulus(27, 32, -1, -1, "t3_sync",    1'b0, 1'b0, 1'b1, 32, 20);
    applyStimulus(27, 32, -1, -1, "t3_measure", 1'b0, 1'b0, 1'b1, 32, 20);
    applyStimulus(27, 32, -1, -1, "t3_stab2",   1'b0, 1'b0, 1'b1, 32, 20);
    applyStimulus(27, 32, -1, -1, "t3_stab3",   1'b0, 1'b0, 1'b1, 32, 20);
    applyStimulus(27, 32, -1, -1, "t3_relock",  1'b1, 1'b1, 1'b1, 32, 27);
    applyStimulus(27, 32,  5, -1, "t3_lostclr", 1'b1, 1'b1, 1'b0, 32, 27);

    applyStimulus(27, 32, -1,  8, "t6_vchange", 1'b0, 1'b0, 1'b0, 32, 27);

    applyStimulus(20, 32, -1, -1, "t4_measure", 1'b0, 1'b0, 1'b0, 32, 27);
    applyStimulus(20, 30, -1, -1, "t4_jit30",   1'b0, 1'b0, 1'b0, 32, 27);
    applyStimulus(20, 34, -1, -1, "t4_jit34",   1'b0, 1'b0, 1'b0, 32, 27);
    applyStimulus(20, 37, -1, -1, "t4_jump37",  1'b0, 1'b0, 1'b0, 32, 27);
    applyStimulus(20, 35, -1, -1, "t4_jit35",   1'b0, 1'b0, 1'b0, 32, 27);
    applyStimulus(20, 33, -1, -1, "t4_tol4",    1'b0, 1'b0, 1'b0, 32, 27);
    applyStimulus(20, 37, -1, -1, "t4_lock",    1'b1, 1'b1, 1'b0, 37, 20);

    applyStimulus(20, 37, -1, -1, "t5_locked",  1'b1, 1'b1, 1'b0, 37, 20);
    applyStimulus(130, 37, -1, -1, "t5_timeout", 1'b0, 1'b0, 1'b1, 37, 20);
    applyStimulus(20, 37,  5, -1, "t5_lostclr", 1'b0, 1'b0, 1'b0, 37, 20);

    for (int c = 0; c < 4; c++) driveCycle(1'b0, 1'b0);
    checkOutput();
    driveCycle(1'b1, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
